// File: rtl/expacc_mem_arbiter_if.sv
// Avalon-MM style request/response bundle between one master and the
// memory arbiter. The requester uses the master modport and the arbiter
// uses the slave modport.
interface expacc_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/expacc_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port on-chip
// memory. m0 is the host CPU, m1 the exponent accelerator, which may keep
// the grant across transfers (lock) until a bounded starvation limit for
// m0 is reached. Grants are combinational; read data returns one cycle
// after the grant and is tagged to its owner.
module expacc_mem_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  expacc_mem_arbiter_if.slave m0,
  expacc_mem_arbiter_if.slave m1,
  input  logic                m1_lock,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int CNT_W = 8;

  typedef enum logic {SEL_M0 = 1'b0, SEL_M1 = 1'b1} sel_t;

  sel_t             rr_ptr, rr_ptr_nxt;
  sel_t             rd_owner, rd_owner_nxt;
  sel_t             gnt_sel;
  logic             gnt_vld;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             last_m1_lock, last_m1_lock_nxt;
  logic             rd_pending, rd_pending_nxt;
  logic             req0, req1, lock_active;

  // Arbitration, memory mux, response routing and next-state logic
  always_comb begin
    req0        = m0.read | m0.write;
    req1        = m1.read | m1.write;
    // The locked stream continues only while its counter has headroom;
    // once exhausted the round-robin pointer (already at m0) decides.
    lock_active = last_m1_lock & req1 & (lock_cnt < CNT_W'(MAX_LOCK));

    gnt_vld = 1'b0;
    gnt_sel = SEL_M0;
    if (reset_n) begin
      if (req0 && req1) begin
        gnt_vld = 1'b1;
        gnt_sel = lock_active ? SEL_M1 : rr_ptr;
      end else if (req0) begin
        gnt_vld = 1'b1;
        gnt_sel = SEL_M0;
      end else if (req1) begin
        gnt_vld = 1'b1;
        gnt_sel = SEL_M1;
      end
    end

    // With no grant the mux rests on m0 and chipselect/write stay low.
    mem_clken      = 1'b1;
    mem_chipselect = gnt_vld;
    if (gnt_sel == SEL_M1) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      mem_write      = gnt_vld & m1.write;
    end else begin
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_writedata  = m0.writedata;
      mem_write      = gnt_vld & m0.write;
    end

    m0.waitrequest   = !(gnt_vld && (gnt_sel == SEL_M0));
    m1.waitrequest   = !(gnt_vld && (gnt_sel == SEL_M1));
    m0.readdata      = mem_readdata;
    m1.readdata      = mem_readdata;
    // Gating with reset_n drops an in-flight response as soon as reset hits.
    m0.readdatavalid = reset_n & rd_pending & (rd_owner == SEL_M0);
    m1.readdatavalid = reset_n & rd_pending & (rd_owner == SEL_M1);

    rr_ptr_nxt       = rr_ptr;
    rd_owner_nxt     = rd_owner;
    last_m1_lock_nxt = last_m1_lock;
    rd_pending_nxt   = 1'b0;
    lock_cnt_nxt     = lock_cnt;
    if (gnt_vld) begin
      rr_ptr_nxt       = (gnt_sel == SEL_M0) ? SEL_M1 : SEL_M0;
      last_m1_lock_nxt = (gnt_sel == SEL_M1) & m1_lock;
      // read+write together is treated as a write, so no response.
      rd_pending_nxt   = !mem_write;
      rd_owner_nxt     = gnt_sel;
    end

    if (gnt_vld && (gnt_sel == SEL_M0)) begin
      lock_cnt_nxt = '0;
    end else if (!req1) begin
      lock_cnt_nxt = '0;
    end else if (gnt_vld && (gnt_sel == SEL_M1) && lock_active && req0) begin
      lock_cnt_nxt = lock_cnt + 1'b1;
    end
  end

  // Arbitration state and outstanding-read tag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr       <= SEL_M0;
      rd_owner     <= SEL_M0;
      lock_cnt     <= '0;
      last_m1_lock <= 1'b0;
      rd_pending   <= 1'b0;
    end else begin
      rr_ptr       <= rr_ptr_nxt;
      rd_owner     <= rd_owner_nxt;
      lock_cnt     <= lock_cnt_nxt;
      last_m1_lock <= last_m1_lock_nxt;
      rd_pending   <= rd_pending_nxt;
    end
  end

endmodule

// File: tb/tb_expacc_mem_arbiter.sv
// Bench for expacc_mem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model of the arbiter
// and memory contents.
`timescale 1ns/1ps
module tb_expacc_mem_arbiter;
  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 16;
  localparam int DEPTH    = 8192;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              m1_lock;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_writedata, mem_readdata;

  expacc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0if ();
  expacc_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1if ();

  expacc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0if), .m1(m1if), .m1_lock(m1_lock),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Memory device: registered q, byte-enabled writes
  logic [31:0] dev_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) dev_mem[mem_address] <= merge(dev_mem[mem_address], mem_writedata, mem_byteenable);
      else mem_readdata <= dev_mem[mem_address];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          m_rr, m_cnt, m_owner, exp_g;
  bit          m_last, m_pend;
  logic [31:0] m_pdata;

  function automatic bit lock_act();
    return m_last && (m1if.read || m1if.write) && (m_cnt < MAX_LOCK);
  endfunction

  // -1: nobody, 0: m0, 1: m1
  function automatic int predict_grant();
    bit r0 = m0if.read || m0if.write;
    bit r1 = m1if.read || m1if.write;
    if (!reset_n) return -1;
    if (r0 && r1) return lock_act() ? 1 : m_rr;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic bit exp_rdv(int who);
    return reset_n && m_pend && (m_owner == who);
  endfunction

  task automatic tick();
    int g = predict_grant();
    bit la = lock_act();
    bit r0 = m0if.read || m0if.write;
    bit r1 = m1if.read || m1if.write;
    bit rst = !reset_n;
    bit w;
    logic [ADDR_W-1:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    bit lk = m1_lock;
    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_last = 0; m_cnt = 0; m_pend = 0;
    end else begin
      if (g == 0 || !r1) m_cnt = 0;
      else if (g == 1 && la && r0) m_cnt++;
      m_pend = 0;
      if (g >= 0) begin
        m_rr = 1 - g;
        m_last = (g == 1) && lk;
        if (g == 0) begin a = m0if.address; be = m0if.byteenable; wd = m0if.writedata; w = m0if.write; end
        else begin a = m1if.address; be = m1if.byteenable; wd = m1if.writedata; w = m1if.write; end
        if (w) ref_mem[a] = merge(ref_mem[a], wd, be);
        else begin m_pend = 1; m_owner = g; m_pdata = ref_mem[a]; end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    m0if.read = 0; m0if.write = 0; m0if.address = '0; m0if.byteenable = 4'hF; m0if.writedata = '0;
    m1if.read = 0; m1if.write = 0; m1if.address = '0; m1if.byteenable = 4'hF; m1if.writedata = '0;
    m1_lock = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0; m0if.read = 1; m0if.address = 13'd5; m1if.write = 1;
    tick();
    repeat (2) begin
      @(negedge clk);
      total++; if (m0if.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wr0 got=%b exp=1", m0if.waitrequest); end
      total++; if (m1if.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wr1 got=%b exp=1", m1if.waitrequest); end
      total++; if (m0if.readdatavalid !== 1'b0 || m1if.readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b%b exp=00", m0if.readdatavalid, m1if.readdatavalid); end
      total++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rst_cs got=%b%b exp=00", mem_chipselect, mem_write); end
      total++; if (mem_clken !== 1'b1) begin bad++; $display("FAIL rst_clken got=%b exp=1", mem_clken); end
      tick();
    end
    reset_n = 1; m1if.write = 0; m1if.read = 1;
    @(negedge clk);
    total++; if (m0if.waitrequest !== 1'b0 || m1if.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_rrptr got=%b%b exp=01", m0if.waitrequest, m1if.waitrequest); end
    tick();
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_write_read();
    m0if.write = 1; m0if.address = 13'h0010; m0if.byteenable = 4'hF; m0if.writedata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (m0if.waitrequest !== 1'b0) begin bad++; $display("FAIL wr_wait got=%b exp=0", m0if.waitrequest); end
    total++; if (mem_write !== 1'b1 || mem_address !== 13'h0010) begin bad++; $display("FAIL wr_bus got=%b/%h exp=1/0010", mem_write, mem_address); end
    tick();
    m0if.write = 0; m0if.read = 1;
    @(negedge clk);
    total++; if (m0if.waitrequest !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rd_wait got=%b/%b exp=0/0", m0if.waitrequest, mem_write); end
    total++; if (m0if.readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_early got=%b exp=0", m0if.readdatavalid); end
    tick();
    idle_inputs();
    @(negedge clk);
    total++; if (m0if.readdatavalid !== 1'b1) begin bad++; $display("FAIL rd_rdv got=%b exp=1", m0if.readdatavalid); end
    total++; if (m0if.readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", m0if.readdata); end
    total++; if (m1if.readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_rdv1 got=%b exp=0", m1if.readdatavalid); end
    tick();
  endtask

  task automatic test_alternate();
    logic [31:0] d0 = 32'hA0A00001;
    logic [31:0] d1 = 32'hB0B00002;
    m0if.write = 1; m0if.address = 13'd1; m0if.writedata = d0;
    tick();
    idle_inputs();
    m1if.write = 1; m1if.address = 13'd2; m1if.writedata = d1;
    tick();
    m1if.write = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin m0if.read = 1; m0if.address = 13'd1; m1if.read = 1; m1if.address = 13'd2; end
      else idle_inputs();
      @(negedge clk);
      if (i < 4) begin
        total++; if (m0if.waitrequest !== (i % 2 == 1)) begin bad++; $display("FAIL alt_wr0[%0d] got=%b exp=%b", i, m0if.waitrequest, i % 2 == 1); end
        total++; if (m1if.waitrequest !== (i % 2 == 0)) begin bad++; $display("FAIL alt_wr1[%0d] got=%b exp=%b", i, m1if.waitrequest, i % 2 == 0); end
      end
      if (i > 0) begin
        total++; if (m0if.readdatavalid !== ((i - 1) % 2 == 0) || m1if.readdatavalid !== ((i - 1) % 2 == 1)) begin
          bad++; $display("FAIL alt_rdv[%0d] got=%b%b", i, m0if.readdatavalid, m1if.readdatavalid); end
        total++; if (m0if.readdata !== (((i - 1) % 2 == 0) ? d0 : d1)) begin
          bad++; $display("FAIL alt_data[%0d] got=%h exp=%h", i, m0if.readdata, ((i - 1) % 2 == 0) ? d0 : d1); end
      end
      tick();
    end
  endtask

  task automatic test_lock();
    int m1g = 0, run = 0, stall = 0, maxstall = 0, runs = 0, cyc = 0;
    bit g1;
    m0if.read = 1; m0if.address = 13'd3;
    m1if.read = 1; m1if.address = 13'd100; m1_lock = 1;
    while (m1g < 40 && cyc < 200) begin
      exp_g = predict_grant();
      @(negedge clk);
      total++; if (m1if.waitrequest !== (exp_g != 1) || m0if.waitrequest !== (exp_g != 0)) begin
        bad++; $display("FAIL lock_gnt[%0d] got=%b%b exp_g=%0d", cyc, m0if.waitrequest, m1if.waitrequest, exp_g); end
      g1 = !m1if.waitrequest;
      if (g1) begin
        m1g++; run++; stall++;
        if (stall > maxstall) maxstall = stall;
      end else if (!m0if.waitrequest) begin
        if (run != 0) begin
          runs++;
          total++; if (run != MAX_LOCK + 1) begin bad++; $display("FAIL lock_run got=%0d exp=%0d", run, MAX_LOCK + 1); end
        end
        run = 0; stall = 0;
      end
      tick();
      if (g1) m1if.address = m1if.address + 1'b1;
      cyc++;
    end
    total++; if (m1g < 40) begin bad++; $display("FAIL lock_timeout got=%0d exp=40", m1g); end
    total++; if (runs < 2) begin bad++; $display("FAIL lock_runs got=%0d exp>=2", runs); end
    total++; if (maxstall > MAX_LOCK + 1) begin bad++; $display("FAIL lock_stall got=%0d exp<=%0d", maxstall, MAX_LOCK + 1); end
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_byteenable();
    m0if.write = 1; m0if.address = 13'h1FFF; m0if.byteenable = 4'hF; m0if.writedata = 32'hFFFFFFFF;
    @(negedge clk);
    total++; if (mem_address !== 13'h1FFF || mem_byteenable !== 4'hF) begin bad++; $display("FAIL be_bus got=%h/%h exp=1fff/f", mem_address, mem_byteenable); end
    tick();
    m0if.byteenable = 4'h3; m0if.writedata = 32'h12345678;
    @(negedge clk);
    total++; if (mem_byteenable !== 4'h3 || mem_writedata !== 32'h12345678) begin bad++; $display("FAIL be_wd got=%h/%h exp=3/12345678", mem_byteenable, mem_writedata); end
    tick();
    m0if.write = 0; m0if.read = 1; m0if.byteenable = 4'hF;
    tick();
    m0if.address = 13'h0000;
    @(negedge clk);
    total++; if (m0if.readdatavalid !== 1'b1 || m0if.readdata !== 32'hFFFF5678) begin bad++; $display("FAIL be_data got=%b/%h exp=1/ffff5678", m0if.readdatavalid, m0if.readdata); end
    tick();
    idle_inputs();
    @(negedge clk);
    total++; if (m0if.readdatavalid !== 1'b1 || m0if.readdata !== 32'h0) begin bad++; $display("FAIL be_nowrap got=%b/%h exp=1/0", m0if.readdatavalid, m0if.readdata); end
    tick();
  endtask

  task automatic test_reset_midread();
    m1if.read = 1; m1if.address = 13'd2;
    @(negedge clk);
    total++; if (m1if.waitrequest !== 1'b0) begin bad++; $display("FAIL mr_gnt got=%b exp=0", m1if.waitrequest); end
    tick();
    reset_n = 0; m0if.read = 1; m0if.address = 13'd5; m1if.address = 13'd7;
    @(negedge clk);
    total++; if (m0if.waitrequest !== 1'b1 || m1if.waitrequest !== 1'b1) begin bad++; $display("FAIL mr_wait got=%b%b exp=11", m0if.waitrequest, m1if.waitrequest); end
    total++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL mr_cs got=%b exp=0", mem_chipselect); end
    total++; if (m1if.readdatavalid !== 1'b0) begin bad++; $display("FAIL mr_rdv_rst got=%b exp=0", m1if.readdatavalid); end
    tick();
    reset_n = 1; idle_inputs();
    @(negedge clk);
    total++; if (m1if.readdatavalid !== 1'b0 || m0if.readdatavalid !== 1'b0) begin bad++; $display("FAIL mr_rdv_after got=%b%b exp=00", m0if.readdatavalid, m1if.readdatavalid); end
    tick();
  endtask

  task automatic test_idle();
    m0if.write = 1; m0if.address = 13'd20; m0if.writedata = 32'h55AA55AA;
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b1) begin
        bad++; $display("FAIL idle_bus[%0d] got=%b%b%b exp=001", i, mem_chipselect, mem_write, mem_clken); end
      total++; if (m0if.readdatavalid !== 1'b0 || m1if.readdatavalid !== 1'b0) begin
        bad++; $display("FAIL idle_rdv[%0d] got=%b%b exp=00", i, m0if.readdatavalid, m1if.readdatavalid); end
      tick();
    end
    m0if.read = 1; m0if.address = 13'd20; m1if.read = 1; m1if.address = 13'd21;
    @(negedge clk);
    total++; if (m1if.waitrequest !== 1'b0 || m0if.waitrequest !== 1'b1) begin bad++; $display("FAIL idle_rrptr got=%b%b exp=10", m0if.waitrequest, m1if.waitrequest); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    bit hold0 = 0, hold1 = 0;
    int k;
    logic [31:0] expd;
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      if (!hold0) begin
        k = $urandom_range(0, 4);
        m0if.read = (k == 1 || k == 2 || k == 4); m0if.write = (k == 3 || k == 4);
        m0if.address = ADDR_W'($urandom_range(0, 7)); m0if.byteenable = 4'($urandom_range(0, 15));
        m0if.writedata = $urandom;
      end
      if (!hold1) begin
        k = $urandom_range(0, 4);
        m1if.read = (k == 1 || k == 2 || k == 4); m1if.write = (k == 3 || k == 4);
        m1if.address = ADDR_W'($urandom_range(0, 7)); m1if.byteenable = 4'($urandom_range(0, 15));
        m1if.writedata = $urandom; m1_lock = ($urandom_range(0, 3) != 0);
      end
      exp_g = predict_grant();
      @(negedge clk);
      total++; if (m0if.waitrequest !== (exp_g != 0) || m1if.waitrequest !== (exp_g != 1)) begin
        bad++; $display("FAIL rnd_gnt[%0d] got=%b%b exp_g=%0d", i, m0if.waitrequest, m1if.waitrequest, exp_g); end
      total++; if (mem_chipselect !== (exp_g >= 0)) begin bad++; $display("FAIL rnd_cs[%0d] got=%b exp=%b", i, mem_chipselect, exp_g >= 0); end
      total++; if (mem_write !== ((exp_g == 0) ? m0if.write : (exp_g == 1) ? m1if.write : 1'b0)) begin
        bad++; $display("FAIL rnd_we[%0d] got=%b exp_g=%0d", i, mem_write, exp_g); end
      total++; if (m0if.readdatavalid !== exp_rdv(0) || m1if.readdatavalid !== exp_rdv(1)) begin
        bad++; $display("FAIL rnd_rdv[%0d] got=%b%b exp=%b%b", i, m0if.readdatavalid, m1if.readdatavalid, exp_rdv(0), exp_rdv(1)); end
      if (exp_rdv(0) || exp_rdv(1)) begin
        expd = m_pdata;
        total++; if ((exp_rdv(0) ? m0if.readdata : m1if.readdata) !== expd) begin
          bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, exp_rdv(0) ? m0if.readdata : m1if.readdata, expd); end
      end
      hold0 = (m0if.read || m0if.write) && exp_g != 0;
      hold1 = (m1if.read || m1if.write) && exp_g != 1;
      tick();
    end
    reset_n = 1;
    idle_inputs();
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin dev_mem[i] = '0; ref_mem[i] = '0; end
    m_rr = 0; m_cnt = 0; m_owner = 0; m_last = 0; m_pend = 0; m_pdata = '0; exp_g = -1;
    reset_n = 0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_alternate();
    test_lock();
    test_byteenable();
    test_reset_midread();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expacc_mem_arbiter.md
Name: expacc_mem_arbiter

Overview:
Two-master arbiter that shares the single-port 8192x32 on-chip memory between the host CPU data master (port m0) and the exponent accelerator operand/result engine (port m1). It presents one Avalon-MM slave interface per master, with waitrequest and readdatavalid, and drives the memory's chipselect/write/address/byteenable/writedata/clken. Grants are round-robin, per transfer. Master m1 may lock the memory for back-to-back operand streaming, bounded by a starvation limit.

Parameters:
ADDR_W, 13, word address width (8192 words)
DATA_W, 32, data width; byteenable width is DATA_W/8
MAX_LOCK, 16, maximum consecutive m1 grants under lock while m0 is waiting (range 1..255)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
m0_address  in  ADDR_W  CPU word address
m0_byteenable  in  4  CPU byte enables
m0_read  in  1  CPU read request
m0_write  in  1  CPU write request
m0_writedata  in  DATA_W  CPU write data
m0_waitrequest  out  1  CPU stall
m0_readdata  out  DATA_W  CPU read data
m0_readdatavalid  out  1  CPU read data valid
m1_address, m1_byteenable, m1_read, m1_write, m1_writedata  in  as m0  accelerator request
m1_lock  in  1  accelerator requests that it keep the grant after this transfer
m1_waitrequest, m1_readdata, m1_readdatavalid  out  as m0  accelerator response
mem_address  out  ADDR_W  to memory address
mem_byteenable  out  4  to memory byteenable
mem_chipselect  out  1  to memory chipselect
mem_write  out  1  to memory write
mem_writedata  out  DATA_W  to memory writedata
mem_clken  out  1  memory clock enable
mem_readdata  in  DATA_W  from memory q (valid 1 cycle after address)

Behaviour:
- Reset (reset_n=0 at a clk edge): both waitrequest=1, both readdatavalid=0, mem_chipselect=0, mem_write=0, rr_ptr=m0, lock_cnt=0, rd_pending=0. mem_clken=1 at all times, including during reset.
- A master requests when its read or write is high. read and write high together from the same master is illegal; the arbiter treats it as a write.
- Grant is combinational in the request cycle. Granted master: waitrequest=0, and its address/byteenable/writedata/write are muxed to the memory with mem_chipselect=1. Losing master: waitrequest=1, and it must hold its request stable.
- With no request: mem_chipselect=0, mem_write=0, and the mem_address/byteenable/writedata mux defaults to m0.
- Arbitration:
  - Only one master requesting: it is granted.
  - Both requesting: grant goes to rr_ptr.
  - After each granted transfer, rr_ptr moves to the other master.
  - Exception: lock_active (below) holds the grant with m1.
- Lock:
  - lock_active=1 when the previous granted transfer was m1 with m1_lock=1, m1 is requesting this cycle, and lock_cnt < MAX_LOCK.
  - lock_cnt increments on each m1 grant made while lock_active=1 and m0 is requesting. It clears to 0 on any m0 grant and on any cycle where m1 is not requesting.
  - When lock_cnt reaches MAX_LOCK, the next cycle in which both masters request grants m0.
- Read latency is fixed at 1:
  - A granted read sets rd_pending=1 and rd_owner to the granted master at the clock edge.
  - In the next cycle, the owner's readdatavalid=1 and its readdata=mem_readdata.
  - Non-owner readdatavalid=0. Both readdata ports carry mem_readdata continuously.
  - Back-to-back reads (same or alternating masters) give a readdatavalid every cycle with no bubble.
- Writes take effect at the grant edge and produce no response.
- A read and a write to the same address in consecutive cycles return the value written by the earlier transfer. A write followed by a read of the same address returns the new data.
- Reset during an outstanding read: the pending readdatavalid is cancelled (0 in the cycle after reset).

Test Plan:
1. Reset, then m0 write 0xDEADBEEF to addr 0x0010 (be=0xF), m0 read 0x0010 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
2. Both masters hold reads (m0 addr 0x0001, m1 addr 0x0002) for 4 cycles with lock=0 -> grants alternate m0,m1,m0,m1; readdatavalid alternates the same way one cycle later with the correct data each time.
3. m1_lock=1, m1 streams 40 reads while m0 requests continuously, MAX_LOCK=16 -> m1 gets 17 consecutive grants (initial grant plus 16 locked), then m0 gets 1 grant, then the pattern repeats; m0 is never stalled for more than 17 cycles.
4. m0 write be=0x3 data 0x12345678 over 0xFFFFFFFF at addr 0x1FFF, then read -> 0xFFFF5678; address 0x1FFF hits the top word with no wrap.
5. Assert reset_n=0 in the cycle after an m1 read grant -> m1_readdatavalid=0 in the following cycle; both waitrequest=1 while reset_n=0; mem_chipselect=0.
6. Idle with no requests for 10 cycles -> mem_chipselect=0, mem_write=0, mem_clken=1, no readdatavalid pulses, and rr_ptr unchanged.
